// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the UART transmitter slice.
// Holds the parity mode and transmitter FSM state enums.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_e;

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// sync_fifo: single-clock FIFO of DEPTH entries, W bits wide.
// Ports: clk, rstn, push_i, pop_i, data_i, data_o, full_o, empty_o, level_o.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [W-1:0]               data_i,
    output logic [W-1:0]               data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [LW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q];
    assign level_o = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, beats split into words, LSB first.
// Ports: clk, rstn, s_valid/s_ready/s_data, tx, busy, level (+cts_n with UART_TX_CTS_EN).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_OUT            = 16,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int DEPTH            = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
`ifdef UART_TX_CTS_EN
    input  logic                       cts_n,
`endif
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [W_OUT-1:0]           s_data,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int NW = W_OUT / BITS_PER_WORD;
    localparam int CW = $clog2(STOP_BITS * CLOCKS_PER_PULSE);
    localparam int BW = $clog2(BITS_PER_WORD);
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    localparam parity_e       PMODE     = parity_e'(PARITY);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLOCKS_PER_PULSE - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WW-1:0]    wrd_q, wrd_d;
    logic [W_OUT-1:0] sh_q, sh_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             rdy_q;

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [W_OUT-1:0] fdata;
    logic [LW-1:0]    flvl;
    logic [LW-1:0]    lvl_nxt;
    logic             go;
    logic             tick;

    sync_fifo #(
        .W     (W_OUT),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (s_data),
        .data_o  (fdata),
        .full_o  (full),
        .empty_o (empty),
        .level_o (flvl)
    );

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_q;

    // Resets to "not clear" so nothing leaves before cts_n is seen low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cts_q <= 2'b11;
        end else begin
            cts_q <= {cts_q[0], cts_n};
        end
    end

    assign go = !cts_q[1];
`else
    assign go = 1'b1;
`endif

    assign push    = s_valid && rdy_q && !full;
    assign lvl_nxt = flvl + LW'(push) - LW'(pop);
    assign tick    = (cnt_q == '0);

    assign s_ready = rdy_q;
    assign tx      = tx_q;
    assign busy    = (state_q != IDLE) || !empty;
    assign level   = flvl;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        wrd_d   = wrd_q;
        sh_d    = sh_q;
        par_d   = par_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty && go) begin
                    pop     = 1'b1;
                    sh_d    = fdata;
                    wrd_d   = '0;
                    cnt_d   = BIT_LAST;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    cnt_d   = BIT_LAST;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                    par_d   = sh_q[0];
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d = BIT_LAST;
                    // Shifting once per bit leaves the next word at the bottom.
                    sh_d  = sh_q >> 1;
                    if (bit_q == BW'(BITS_PER_WORD - 1)) begin
                        if (PMODE != PAR_NONE) begin
                            state_d = PAR;
                            tx_d    = (PMODE == PAR_ODD) ? ~par_q : par_q;
                        end else begin
                            state_d = STOP;
                            cnt_d   = STOP_LAST;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = sh_q[1];
                        par_d = par_q ^ sh_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PAR: begin
                if (tick) begin
                    state_d = STOP;
                    cnt_d   = STOP_LAST;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    if (wrd_q != WW'(NW - 1)) begin
                        wrd_d   = wrd_q + 1'b1;
                        cnt_d   = BIT_LAST;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else if (!empty && go) begin
                        pop     = 1'b1;
                        sh_d    = fdata;
                        wrd_d   = '0;
                        cnt_d   = BIT_LAST;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            wrd_q   <= '0;
            sh_q    <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            wrd_q   <= wrd_d;
            sh_q    <= sh_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            // Ready looks ahead at the post-edge fill so a full FIFO is never pushed.
            rdy_q   <= (lvl_nxt != LW'(DEPTH));
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed/random bench for uart_tx_fifo with a serial receiver model.
// Two instances: even parity/1 stop and odd parity/2 stops; UART_TX_CTS_EN adds cts_n.
module tb_uart_tx_fifo;

    localparam int CPP = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        va, vb;
    logic [15:0] da, db;
    logic        rdya, rdyb;
    logic        txa, txb;
    logic        busya, busyb;
    logic [2:0]  lvla, lvlb;
`ifdef UART_TX_CTS_EN
    logic        cts_n = 1'b0;
`endif

    int nerr = 0;
    int nchk = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(
        .CLOCKS_PER_PULSE (CPP),
        .BITS_PER_WORD    (8),
        .W_OUT            (16),
        .PARITY           (2),
        .STOP_BITS        (1),
        .DEPTH            (4)
    ) u_a (
        .clk     (clk),
        .rstn    (rstn),
`ifdef UART_TX_CTS_EN
        .cts_n   (cts_n),
`endif
        .s_valid (va),
        .s_ready (rdya),
        .s_data  (da),
        .tx      (txa),
        .busy    (busya),
        .level   (lvla)
    );

    uart_tx_fifo #(
        .CLOCKS_PER_PULSE (CPP),
        .BITS_PER_WORD    (8),
        .W_OUT            (16),
        .PARITY           (1),
        .STOP_BITS        (2),
        .DEPTH            (4)
    ) u_b (
        .clk     (clk),
        .rstn    (rstn),
`ifdef UART_TX_CTS_EN
        .cts_n   (cts_n),
`endif
        .s_valid (vb),
        .s_ready (rdyb),
        .s_data  (db),
        .tx      (txb),
        .busy    (busyb),
        .level   (lvlb)
    );

    // Serial receiver: samples each bit half a clock in, records frames and start cycles.
    wire [1:0]   txv = {txb, txa};
    bit          act [2];
    int          rc [2];
    logic [15:0] rb [2];
    logic [15:0] rf [2][64];
    int          rt [2][64];
    int          rn [2] = '{0, 0};

    function automatic int flen(input int c);
        return (c == 0) ? 11 : 12;
    endfunction

    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (!rstn) begin
                act[c] <= 1'b0;
            end else if (!act[c]) begin
                if (!txv[c]) begin
                    act[c] <= 1'b1;
                    rc[c] <= 1;
                    rb[c] <= '0;
                    rt[c][rn[c]] <= cyc;
                end
            end else begin
                rc[c] <= rc[c] + 1;
                if (rc[c] % CPP == 0) begin
                    rb[c][rc[c] / CPP] <= txv[c];
                    if (rc[c] / CPP == flen(c) - 1) begin
                        rf[c][rn[c]] <= rb[c] | (16'(txv[c]) << (rc[c] / CPP));
                        rn[c] <= rn[c] + 1;
                        act[c] <= 1'b0;
                    end
                end
            end
        end
    end

    // Expected serial frame, bit i = i-th bit on the line.
    function automatic logic [15:0] expf(input logic [7:0] w, input int par,
                                         input int stops);
        logic [15:0] f;
        int fl;
        f = '0;
        fl = 9 + ((par != 0) ? 1 : 0) + stops;
        for (int i = 0; i < 8; i++) f[1 + i] = w[i];
        if (par != 0) f[9] = (^w) ^ (par == 1);
        for (int i = 9 + ((par != 0) ? 1 : 0); i < fl; i++) f[i] = 1'b1;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic push(input int c, input logic [15:0] d, output int acc);
        int t;
        t = 0;
        if (c == 0) begin
            va = 1'b1;
            da = d;
        end else begin
            vb = 1'b1;
            db = d;
        end
        while (!((c == 0) ? rdya : rdyb) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("push%0d_ready", c), 32'((c == 0) ? rdya : rdyb), 1);
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
    endtask

    task automatic wait_rx(input int c, input int n, input string tag);
        int t;
        t = 0;
        while (rn[c] < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(rn[c] >= n), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc1, base, t;
        logic [15:0] d, b;
        logic [15:0] bq[$];
        logic [7:0] w;

        va = 1'b0;
        vb = 1'b0;
        da = '0;
        db = '0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", txa, 1);
        chk("rst_ready", rdya, 0);
        chk("rst_busy", busya, 0);
        chk("rst_level", lvla, 0);
        chk("rst_tx_b", txb, 1);
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_rise", rdya, 1);

        // Single beat, even parity.
        base = rn[0];
        push(0, 16'hA53C, acc);
        va = 1'b0;
        wait_rx(0, base + 2, "t1_rx");
        chk("t1_w0", rf[0][base], expf(8'h3C, 2, 1));
        chk("t1_w1", rf[0][base + 1], expf(8'hA5, 2, 1));
        chk("t1_par0", rf[0][base][9], 0);
        chk("t1_par1", rf[0][base + 1][9], 0);
        chk("t1_lat", rt[0][base], acc + 1);
        chk("t1_gap", rt[0][base + 1] - rt[0][base], 44);
        while (cyc < acc + 88) @(negedge clk);
        chk("t1_busy_hi", busya, 1);
        @(negedge clk);
        chk("t1_busy_lo", busya, 0);
        chk("t1_tx_idle", txa, 1);

        // Odd parity, two stop bits.
        base = rn[1];
        push(1, 16'h0100, acc);
        vb = 1'b0;
        wait_rx(1, base + 2, "t2_rx");
        chk("t2_w0", rf[1][base], expf(8'h00, 1, 2));
        chk("t2_w1", rf[1][base + 1], expf(8'h01, 1, 2));
        chk("t2_par0", rf[1][base][9], 1);
        chk("t2_par1", rf[1][base + 1][9], 0);
        chk("t2_lat", rt[1][base], acc + 1);
        chk("t2_gap", rt[1][base + 1] - rt[1][base], 48);

        // Burst of six random beats with valid held high.
        base = rn[0];
        for (int i = 0; i < 6; i++) begin
            d = 16'($urandom());
            bq.push_back(d);
            push(0, d, acc);
            if (i == 4) begin
                chk("burst_level", lvla, 4);
                chk("burst_full", rdya, 0);
            end
        end
        va = 1'b0;
        wait_rx(0, base + 12, "burst_rx");
        for (int k = 0; k < 12; k++) begin
            b = bq[k / 2];
            w = (k % 2 == 0) ? b[7:0] : b[15:8];
            chk($sformatf("burst_w%0d", k), rf[0][base + k], expf(w, 2, 1));
            if (k > 0)
                chk($sformatf("burst_gap%0d", k),
                    rt[0][base + k] - rt[0][base + k - 1], 44);
        end
        t = 0;
        while (busya && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("burst_idle", busya, 0);
        chk("burst_level0", lvla, 0);

        // Reset during data bit 3 of word 0 with two beats queued.
        d = 16'($urandom()) & 16'hFFF7;
        push(0, d, acc1);
        push(0, 16'($urandom()), acc);
        push(0, 16'($urandom()), acc);
        va = 1'b0;
        chk("mid_level", lvla, 2);
        while (cyc < acc1 + 18) @(negedge clk);
        chk("mid_bit3", txa, 0);
        #1 rstn = 1'b0;
        #1;
        chk("mid_rst_tx", txa, 1);
        chk("mid_rst_level", lvla, 0);
        chk("mid_rst_busy", busya, 0);
        chk("mid_rst_ready", rdya, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        base = rn[0];
        push(0, 16'h1234, acc);
        va = 1'b0;
        wait_rx(0, base + 2, "post_rx");
        chk("post_w0", rf[0][base], expf(8'h34, 2, 1));
        chk("post_w1", rf[0][base + 1], expf(8'h12, 2, 1));
        chk("post_lat", rt[0][base], acc + 1);
        repeat (150) @(negedge clk);
        chk("post_nframes", rn[0], base + 2);
        chk("post_busy", busya, 0);

`ifdef UART_TX_CTS_EN
        cts_n = 1'b1;
        repeat (4) @(negedge clk);
        base = rn[0];
        bq.delete();
        for (int i = 0; i < 2; i++) begin
            d = 16'($urandom());
            bq.push_back(d);
            push(0, d, acc);
        end
        va = 1'b0;
        repeat (20) @(negedge clk);
        chk("cts_hold_tx", txa, 1);
        chk("cts_level", lvla, 2);
        chk("cts_nframes", rn[0], base);
        cts_n = 1'b0;
        t = 0;
        while (txa && t < 4) begin
            @(negedge clk);
            t++;
        end
        chk("cts_start", txa, 0);
        repeat (10) @(negedge clk);
        cts_n = 1'b1;
        wait_rx(0, base + 2, "cts_rx1");
        repeat (100) @(negedge clk);
        chk("cts_mid_nframes", rn[0], base + 2);
        chk("cts_mid_level", lvla, 1);
        chk("cts_mid_tx", txa, 1);
        b = bq[0];
        chk("cts_w0", rf[0][base], expf(b[7:0], 2, 1));
        chk("cts_w1", rf[0][base + 1], expf(b[15:8], 2, 1));
        cts_n = 1'b0;
        wait_rx(0, base + 4, "cts_rx2");
        b = bq[1];
        chk("cts_w2", rf[0][base + 2], expf(b[7:0], 2, 1));
        chk("cts_w3", rf[0][base + 3], expf(b[15:8], 2, 1));
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter. It sits between an AXI-Stream-style producer and a serial line.
- Accepts W_OUT-bit beats into an internal FIFO.
- Splits each beat into BITS_PER_WORD-bit words and sends them lowest word first, LSB first.
- Framing per word: start bit, data, optional odd/even parity, then 1 or 2 stop bits.
- Consecutive frames go back-to-back without idle gaps while data is queued.

Parameters:
CLOCKS_PER_PULSE, 4, clocks per UART bit (>=2).
BITS_PER_WORD, 8, data bits per frame (5..9).
W_OUT, 16, input beat width; must be a multiple of BITS_PER_WORD.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
DEPTH, 4, FIFO depth in beats (power of 2, >=2).

Ports:
clk  in  1  clock.
rstn  in  1  asynchronous, active-low reset.
s_valid  in  1  beat valid.
s_ready  out  1  FIFO can accept a beat.
s_data  in  W_OUT  beat; word k = s_data[k*BITS_PER_WORD +: BITS_PER_WORD].
tx  out  1  serial line, idle high.
busy  out  1  FSM not IDLE or FIFO non-empty.
level  out  $clog2(DEPTH+1)  beats currently in FIFO.

Behaviour:
- Interface: one clock clk; reset rstn is asynchronous, active-low.
- Reset values: tx=1, s_ready=0, busy=0, level=0, FSM=IDLE, FIFO empty.
  - s_ready is registered and rises at the first clk edge after rstn deasserts.
- Reset mid-frame: tx goes to 1 immediately (async), the FIFO is flushed and the partial frame is dropped.
- Handshake:
  - A beat is written on a clk edge where s_valid && s_ready.
  - s_ready = !full, registered.
  - A write and a pop on the same edge are both honoured; level is unchanged.
  - When full, s_ready=0. A pop raises s_ready on the following edge.
  - s_data is sampled only on the accept edge.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START: FIFO non-empty. Pop the beat into the shift register, set word index = 0, tx=0.
  - START -> DATA after CLOCKS_PER_PULSE clocks.
  - DATA: shifts BITS_PER_WORD bits, LSB first, one per CLOCKS_PER_PULSE clocks.
  - DATA -> PAR if PARITY != 0, else DATA -> STOP.
  - PAR: parity bit = XOR of the data word, inverted for odd parity.
  - STOP: STOP_BITS*CLOCKS_PER_PULSE clocks of tx=1. Exit:
    - index < NUM_WORDS-1: increment index, go to START.
    - else, FIFO non-empty: pop and go to START (no idle bit).
    - else: go to IDLE.
- Timing and latency:
  - A baud down-counter reloads with CLOCKS_PER_PULSE-1 on every bit boundary.
  - tx is registered and each bit lasts exactly CLOCKS_PER_PULSE clocks.
  - Latency: beat accepted at edge N into an empty FIFO with FSM idle -> tx=0 after edge N+1.
- Frame length: 1 + BITS_PER_WORD + (PARITY != 0) + STOP_BITS bits. NUM_WORDS = W_OUT/BITS_PER_WORD.
- level: counts beats in FIFO only, excluding the beat in the shift register. Wraps never; saturates by construction at DEPTH.

Optional Feature:
UART_TX_CTS_EN
- Defined:
  - Adds input port cts_n (1 bit, active-low clear-to-send, synchronised through 2 flops inside the block).
  - The FSM leaves IDLE, or starts the next beat from STOP, only while the synchronised cts_n=0.
  - A beat already in progress finishes all of its words.
  - cts_n high holds tx=1 with the FIFO filling.
- Undefined: no port; the block behaves as if cts_n=0 always.

Decomposition:
- Package uart_pkg: parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN) and state_e enum (IDLE, START, DATA, PAR, STOP).
- Sub-module sync_fifo: parametrised width W_OUT and depth DEPTH, with push/pop/full/empty/level and async active-low reset on clk/rstn.
- The shift register and counters stay in uart_tx_fifo.

Test Plan:
- Defaults, PARITY=2 (11-bit frame, 44 clocks per word): s_data=16'hA53C -> word 3C then A5, even parity bits 0 and 0, 88 clocks total, busy falls after the last stop bit.
- PARITY=1, STOP_BITS=2, s_data=16'h0100 -> word 00 parity 1, word 01 parity 0; each frame 12 bits; stop bits and padding all 1.
- Burst of 6 beats, s_valid held high, DEPTH=4 -> s_ready drops after 4 beats are queued; the 5th and 6th are accepted as pops occur; frames are contiguous with no idle bit; all 12 words are received in order.
- Reset mid-frame: rstn=0 in the DATA bit 3 of word 0 with 2 beats queued -> tx=1 asynchronously, level=0; after release a new beat 16'h1234 is sent correctly.
- UART_TX_CTS_EN: cts_n=1 with 2 beats queued -> tx stays 1, level=2; cts_n=0 -> transmission starts within 3 clocks. Raising cts_n mid-beat -> the beat's remaining word still completes and the next beat waits.
